id_ex_stage: RTL

Pipeline register between the instruction decoder/control unit and the execute stage of the RV32I core. Each cycle it captures the decoded operands, immediate, register indices and the full control bundle produced for the instruction in ID (reg_write, alu_src_a/b, mem_write, mem_read, mem_to_reg, pc_src, alu_op). It detects load-use hazards against the instruction already in EX, inserts one bubble per hazard, and honours downstream hold and flush. It also keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage_pkg.sv | 41 ++++
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/id_ex_stage_load_use_hazard.sv | 26 ++
 rtl/id_ex_stage.sv | 87 ++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: RV32I opcodes, the control
// bundle, and a helper that turns a control bundle into a bubble.
package id_ex_stage_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;

  // These mirror the RV32I encodings in the core's shared opcode header.
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_ARI_RTYPE = 7'b0110011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Clear the bits that cause architectural side effects; other fields stay.
  function automatic ctrl_t kill_enables(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    r.mem_read  = 1'b0;
    r.pc_src    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bus: decoded instruction in, registered EX slot out, plus
// handshake, hazard flag and bubble counter.
interface id_ex_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7_b5;
  logic            id_reg_write, id_mem_write, id_mem_read, id_mem_to_reg, id_pc_src;
  logic [1:0]      id_alu_src_a, id_alu_src_b, id_alu_op;
  logic            ex_ready;
  logic            flush;

  logic            id_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7_b5;
  logic            ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_pc_src;
  logic [1:0]      ex_alu_src_a, ex_alu_src_b, ex_alu_op;
  logic            hazard;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_opcode, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7_b5,
           id_reg_write, id_mem_write, id_mem_read, id_mem_to_reg, id_pc_src,
           id_alu_src_a, id_alu_src_b, id_alu_op, ex_ready, flush,
    input  id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_b5,
           ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_pc_src,
           ex_alu_src_a, ex_alu_src_b, ex_alu_op, hazard, bubble_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7_b5,
           id_reg_write, id_mem_write, id_mem_read, id_mem_to_reg, id_pc_src,
           id_alu_src_a, id_alu_src_b, id_alu_op, ex_ready, flush,
    output id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_b5,
           ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_pc_src,
           ex_alu_src_a, ex_alu_src_b, ex_alu_op, hazard, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_load_use_hazard.sv
// Load-use hazard detect: the ID instruction reads a register that the load
// currently in EX has not produced yet.
module load_use_hazard
  import id_ex_stage_pkg::*;
(
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);
  logic uses_rs1;
  logic uses_rs2;

  assign uses_rs1 = !((id_opcode == OPC_LUI) || (id_opcode == OPC_AUIPC) ||
                      (id_opcode == OPC_JAL));
  assign uses_rs2 = (id_opcode == OPC_ARI_RTYPE) || (id_opcode == OPC_STORE) ||
                    (id_opcode == OPC_BRANCH);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != REG_W'(0)) &&
                  ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold, flush and a
// saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  ctrl_t id_ctrl;
  ctrl_t ex_ctrl_q;
  logic  hazard;

  assign id_ctrl = '{reg_write:  bus.id_reg_write,
                     mem_write:  bus.id_mem_write,
                     mem_read:   bus.id_mem_read,
                     mem_to_reg: bus.id_mem_to_reg,
                     pc_src:     bus.id_pc_src,
                     alu_src_a:  bus.id_alu_src_a,
                     alu_src_b:  bus.id_alu_src_b,
                     alu_op:     bus.id_alu_op};

  load_use_hazard u_hazard (
    .id_valid    (bus.id_valid),
    .id_opcode   (bus.id_opcode),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rd       (bus.ex_rd),
    .hazard      (hazard)
  );

  assign bus.hazard   = hazard;
  assign bus.id_ready = bus.ex_ready && !hazard;

  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign bus.ex_pc_src     = ex_ctrl_q.pc_src;
  assign bus.ex_alu_src_a  = ex_ctrl_q.alu_src_a;
  assign bus.ex_alu_src_b  = ex_ctrl_q.alu_src_b;
  assign bus.ex_alu_op     = ex_ctrl_q.alu_op;

  // EX slot update: flush beats hold beats bubble beats normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q        <= '0;
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= XLEN'(0);
      bus.ex_rs1_data  <= XLEN'(0);
      bus.ex_rs2_data  <= XLEN'(0);
      bus.ex_imm       <= XLEN'(0);
      bus.ex_rs1       <= REG_W'(0);
      bus.ex_rs2       <= REG_W'(0);
      bus.ex_rd        <= REG_W'(0);
      bus.ex_funct3    <= 3'(0);
      bus.ex_funct7_b5 <= 1'b0;
      bus.bubble_cnt   <= CNT_W'(0);
    end else if (bus.flush) begin
      ex_ctrl_q    <= kill_enables(ex_ctrl_q);
      bus.ex_valid <= 1'b0;
    end else if (!bus.ex_ready) begin
      ex_ctrl_q    <= ex_ctrl_q;
    end else if (hazard) begin
      ex_ctrl_q    <= kill_enables(ex_ctrl_q);
      bus.ex_valid <= 1'b0;
      if (!(&bus.bubble_cnt)) bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
    end else begin
      ex_ctrl_q        <= bus.id_valid ? id_ctrl : kill_enables(id_ctrl);
      bus.ex_valid     <= bus.id_valid;
      bus.ex_pc        <= bus.id_pc;
      bus.ex_rs1_data  <= bus.id_rs1_data;
      bus.ex_rs2_data  <= bus.id_rs2_data;
      bus.ex_imm       <= bus.id_imm;
      bus.ex_rs1       <= bus.id_rs1;
      bus.ex_rs2       <= bus.id_rs2;
      bus.ex_rd        <= bus.id_rd;
      bus.ex_funct3    <= bus.id_funct3;
      bus.ex_funct7_b5 <= bus.id_funct7_b5;
    end
  end
endmodule
